// File: rtl/video_timing_gen.sv
// video_timing_gen: mode-selectable DE/HS/VS timing with active-pixel coordinates and SOF.
// Optional test-pattern output (O_data_rgb, I_pat_sel) is built when TEST_PATTERN_EN is defined.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int CNT_W     = 12,
  parameter int C_H_TOTAL = 1650,
  parameter int C_H_SYNC  = 40,
  parameter int C_H_BP    = 220,
  parameter int C_H_RES   = 640,
  parameter int C_V_TOTAL = 750,
  parameter int C_V_SYNC  = 5,
  parameter int C_V_BP    = 20,
  parameter int C_V_RES   = 480,
  parameter int C_HS_POL  = 1,
  parameter int C_VS_POL  = 1,
  parameter int C_BAR_W   = 80
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst,
  input  logic [1:0]       I_mode,
`ifdef TEST_PATTERN_EN
  input  logic [1:0]       I_pat_sel,
  output logic [23:0]      O_data_rgb,
`endif
  output logic [1:0]       O_mode_act,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y,
  output logic             O_sof
);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] h_res;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic [CNT_W-1:0] v_res;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // {hs_pol, vs_pol}; 1 = sync pulse is driven high.
  function automatic logic [1:0] mode_pol(input logic [1:0] m);
    case (m)
      2'd1:    mode_pol = 2'b00;
      2'd3:    mode_pol = {C_HS_POL != 0, C_VS_POL != 0};
      default: mode_pol = 2'b11;
    endcase
  endfunction

  function automatic timing_t mk(input int ht, hs, hbp, hres, vt, vs, vbp, vres,
                                 input logic [1:0] pol);
    timing_t t;
    t.h_total = CNT_W'(ht);
    t.h_sync  = CNT_W'(hs);
    t.h_bp    = CNT_W'(hbp);
    t.h_res   = CNT_W'(hres);
    t.v_total = CNT_W'(vt);
    t.v_sync  = CNT_W'(vs);
    t.v_bp    = CNT_W'(vbp);
    t.v_res   = CNT_W'(vres);
    t.hs_pol  = pol[1];
    t.vs_pol  = pol[0];
    return t;
  endfunction

  function automatic timing_t mode_timing(input logic [1:0] m);
    case (m)
      2'd0:    mode_timing = mk(1650, 40, 220, 1280, 750, 5, 20, 720, mode_pol(m));
      2'd1:    mode_timing = mk(1344, 136, 160, 1024, 806, 6, 29, 768, mode_pol(m));
      2'd2:    mode_timing = mk(1056, 128, 88, 800, 628, 4, 23, 600, mode_pol(m));
      default: mode_timing = mk(C_H_TOTAL, C_H_SYNC, C_H_BP, C_H_RES,
                                C_V_TOTAL, C_V_SYNC, C_V_BP, C_V_RES, mode_pol(m));
    endcase
  endfunction

  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  timing_t          tim;
  logic [1:0]       rst_pol;
  logic [CNT_W-1:0] h_start, h_end, v_start, v_end;
  logic             h_last, v_last, hs_raw, vs_raw, de_raw;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tim     = mode_timing(mode_q);
    rst_pol = mode_pol(I_mode);
    h_start = tim.h_sync + tim.h_bp;
    h_end   = h_start + tim.h_res;
    v_start = tim.v_sync + tim.v_bp;
    v_end   = v_start + tim.v_res;

    h_last  = (h_cnt_q == tim.h_total - ONE);
    v_last  = (v_cnt_q == tim.v_total - ONE);
    h_cnt_d = h_cnt_q + ONE;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + ONE;
    end

    // A new mode is only taken on the last pixel of a frame, so the next (0,0) uses it.
    mode_d = (h_last && v_last) ? I_mode : mode_q;

    hs_raw = (h_cnt_q < tim.h_sync);
    vs_raw = (v_cnt_q < tim.v_sync);
    de_raw = (h_cnt_q >= h_start) && (h_cnt_q < h_end) &&
             (v_cnt_q >= v_start) && (v_cnt_q < v_end);

    hs_d  = hs_raw ~^ tim.hs_pol;
    vs_d  = vs_raw ~^ tim.vs_pol;
    de_d  = de_raw;
    x_d   = de_raw ? h_cnt_q - h_start : '0;
    y_d   = de_raw ? v_cnt_q - v_start : '0;
    sof_d = de_raw && (h_cnt_q == h_start) && (v_cnt_q == v_start);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      mode_q  <= I_mode;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~rst_pol[1];
      vs_q    <= ~rst_pol[0];
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
    end
  end

  assign O_mode_act = mode_q;
  assign O_de       = de_q;
  assign O_hs       = hs_q;
  assign O_vs       = vs_q;
  assign O_x        = x_q;
  assign O_y        = y_q;
  assign O_sof      = sof_q;

`ifdef TEST_PATTERN_EN
  logic [CNT_W-1:0] bar_w, bar_pos_q, bar_pos_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [23:0]      rgb_q, rgb_d;

  function automatic logic [CNT_W-1:0] mode_bar_w(input logic [1:0] m);
    case (m)
      2'd0:    mode_bar_w = CNT_W'(160);
      2'd1:    mode_bar_w = CNT_W'(128);
      2'd2:    mode_bar_w = CNT_W'(100);
      default: mode_bar_w = CNT_W'(C_BAR_W);
    endcase
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Bar position tracks the current h_cnt: cleared when the next pixel is the first active one.
  always_comb begin
    bar_w     = mode_bar_w(mode_q);
    bar_pos_d = bar_pos_q + ONE;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == h_start) begin
      bar_pos_d = '0;
      bar_idx_d = 3'd0;
    end else if (bar_pos_q == bar_w - ONE) begin
      bar_pos_d = '0;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end

    fcnt_d = fcnt_q + {7'd0, sof_q};

    rgb_d = '0;
    if (de_raw) begin
      case (I_pat_sel)
        2'd0:    rgb_d = bar_colour(bar_idx_q);
        2'd1:    rgb_d = {x_d[7:0], y_d[7:0], 8'h00};
        2'd2:    rgb_d = {fcnt_q, ~fcnt_q, 8'h00};
        default: rgb_d = 24'hFFFFFF;
      endcase
    end
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      bar_pos_q <= '0;
      bar_idx_q <= 3'd0;
      fcnt_q    <= 8'd0;
      rgb_q     <= 24'd0;
    end else begin
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
      fcnt_q    <= fcnt_d;
      rgb_q     <= rgb_d;
    end
  end

  assign O_data_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small custom mode for whole-frame checks, presets by line.
`timescale 1ns/1ps
module tb_video_timing_gen;

  localparam int CHT = 40, CHS = 4, CHBP = 6, CHR = 20;
  localparam int CVT = 12, CVS = 2, CVBP = 3, CVR = 5;
  localparam int CHP = 0, CVP = 1, CBW = 3;
  localparam int CH0 = CHS + CHBP;
  localparam int CV0 = CVS + CVBP;

  logic        I_pxl_clk = 1'b0;
  logic        I_rst     = 1'b1;
  logic [1:0]  I_mode    = 2'd3;
  logic [1:0]  O_mode_act;
  logic        O_de, O_hs, O_vs, O_sof;
  logic [11:0] O_x, O_y;
`ifdef TEST_PATTERN_EN
  logic [1:0]  I_pat_sel = 2'd0;
  logic [23:0] O_data_rgb;
  localparam logic [23:0] BAR_RGB [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mh, mv, m_fcnt, model_err;

  video_timing_gen #(
    .CNT_W(12), .C_H_TOTAL(CHT), .C_H_SYNC(CHS), .C_H_BP(CHBP), .C_H_RES(CHR),
    .C_V_TOTAL(CVT), .C_V_SYNC(CVS), .C_V_BP(CVBP), .C_V_RES(CVR),
    .C_HS_POL(CHP), .C_VS_POL(CVP), .C_BAR_W(CBW)
  ) dut (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_mode    (I_mode),
`ifdef TEST_PATTERN_EN
    .I_pat_sel (I_pat_sel),
    .O_data_rgb(O_data_rgb),
`endif
    .O_mode_act(O_mode_act),
    .O_de      (O_de),
    .O_hs      (O_hs),
    .O_vs      (O_vs),
    .O_x       (O_x),
    .O_y       (O_y),
    .O_sof     (O_sof)
  );

  always #5 I_pxl_clk = ~I_pxl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge I_pxl_clk);
    @(negedge I_pxl_clk);
  endtask

  task automatic apply_reset(input logic [1:0] m, input logic hs_idle, input logic vs_idle);
    I_mode = m;
    I_rst  = 1'b1;
    step();
    check("rst_mode", O_mode_act, m);
    check("rst_de", O_de, 1'b0);
    check("rst_x", O_x, 0);
    check("rst_y", O_y, 0);
    check("rst_sof", O_sof, 1'b0);
    check("rst_hs", O_hs, hs_idle);
    check("rst_vs", O_vs, vs_idle);
`ifdef TEST_PATTERN_EN
    check("rst_rgb", O_data_rgb, 0);
`endif
    I_rst = 1'b0;
  endtask

  task automatic wait_sof(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!O_sof && n < 50000);
    check(tag, n, exp_n);
  endtask

  // Custom-mode reference: compares the current sample against state (mh,mv), then advances.
  task automatic model_cmp(input int pat);
    logic e_de, e_hs, e_vs, e_sof, bad;
    int   ex, ey;
`ifdef TEST_PATTERN_EN
    logic [23:0] e_rgb;
    logic [7:0]  f;
    int          bi;
`endif
    e_de  = (mh >= CH0) && (mh < CH0 + CHR) && (mv >= CV0) && (mv < CV0 + CVR);
    ex    = e_de ? mh - CH0 : 0;
    ey    = e_de ? mv - CV0 : 0;
    e_hs  = ((mh < CHS) == (CHP != 0));
    e_vs  = ((mv < CVS) == (CVP != 0));
    e_sof = e_de && (ex == 0) && (ey == 0);
    bad = (O_de !== e_de) || (O_x !== 12'(ex)) || (O_y !== 12'(ey)) ||
          (O_hs !== e_hs) || (O_vs !== e_vs) || (O_sof !== e_sof);
`ifdef TEST_PATTERN_EN
    f  = 8'(m_fcnt);
    bi = ex / CBW;
    if (bi > 7) bi = 7;
    e_rgb = 24'h0;
    if (e_de) begin
      case (pat)
        0:       e_rgb = BAR_RGB[bi];
        1:       e_rgb = {ex[7:0], ey[7:0], 8'h00};
        2:       e_rgb = {f, ~f, 8'h00};
        default: e_rgb = 24'hFFFFFF;
      endcase
    end
    bad = bad || (O_data_rgb !== e_rgb);
`else
    if (pat < 0) bad = 1'b1;
`endif
    if (bad) begin
      model_err++;
      if (model_err <= 5)
        $display("  model diff h=%0d v=%0d: de=%0b x=%0d y=%0d hs=%0b vs=%0b sof=%0b",
                 mh, mv, O_de, O_x, O_y, O_hs, O_vs, O_sof);
    end
    if (e_sof) m_fcnt = (m_fcnt + 1) % 256;
    mh++;
    if (mh == CHT) begin
      mh = 0;
      mv++;
      if (mv == CVT) mv = 0;
    end
  endtask

  initial begin
    int n, run, last_x, vs_cnt, rise1, rise2, fall1, fall2, de_cnt;
    logic prev_hs, run_done;
    logic [23:0] rgb159, rgb160, rgb1279;

    // Custom mode: reset state, SOF latency, then three frames against the reference.
    apply_reset(2'd3, 1'b1, 1'b0);
    wait_sof("c_sof_latency", CH0 + CV0 * CHT + 1);
    check("c_sof_x", O_x, 0);
    check("c_sof_y", O_y, 0);
    check("c_sof_de", O_de, 1'b1);
    mh = CH0; mv = CV0; m_fcnt = 0; model_err = 0;
    model_cmp(0);
    for (int i = 1; i < 3 * CHT * CVT; i++) begin
`ifdef TEST_PATTERN_EN
      I_pat_sel = 2'(i / (CHT * CVT));
`endif
      step();
      model_cmp(i / (CHT * CVT));
    end
    check("c_model_3frames", model_err, 0);
    check("c_fcnt_frames", m_fcnt, 3);

    // Mid-frame request for mode 2: the running frame finishes first (sample state 209 -> 479).
`ifdef TEST_PATTERN_EN
    I_pat_sel = 2'd3;
`endif
    I_mode = 2'd2;
    n = 0;
    do begin
      step();
      n++;
      model_cmp(3);
    end while (O_mode_act == 2'd3 && n < 1000);
    check("c_mode_switch_at", n, 270);
    check("c_model_switch", model_err, 0);
    step();
    check("m2_mode_act", O_mode_act, 2'd2);
    check("m2_hs_start", O_hs, 1'b1);
    check("m2_vs_start", O_vs, 1'b1);
    check("m2_de_start", O_de, 1'b0);
    run = 1;
    n = 0;
    run_done = 1'b0;
    do begin
      step();
      n++;
      if (!run_done) begin
        if (O_hs) run++;
        else run_done = 1'b1;
      end
    end while (!(run_done && O_hs) && n < 3000);
    check("m2_hs_width", run, 128);
    check("m2_line_period", n, 1056);

    // Mid-frame reset during active video in custom mode.
    apply_reset(2'd3, 1'b1, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (!(O_de && O_x == 12'd7 && O_y == 12'd2) && n < 1000);
    check("c_seek_active", n, (CV0 + 2) * CHT + CH0 + 7 + 1);
    I_rst = 1'b1;
    step();
    check("c_midrst_de", O_de, 1'b0);
    check("c_midrst_x", O_x, 0);
    check("c_midrst_y", O_y, 0);
    check("c_midrst_sof", O_sof, 1'b0);
    I_rst = 1'b0;
    wait_sof("c_midrst_sof_latency", CH0 + CV0 * CHT + 1);

    // Mode 1: negative syncs.
    apply_reset(2'd1, 1'b1, 1'b1);
    run = 0; run_done = 1'b0; vs_cnt = 0; de_cnt = 0; fall1 = 0; fall2 = 0;
    prev_hs = O_hs;
    for (int i = 1; i <= 8100; i++) begin
      step();
      if (!O_vs) vs_cnt++;
      if (O_de) de_cnt++;
      if (!run_done) begin
        if (!O_hs) run++;
        else run_done = 1'b1;
      end
      if (!O_hs && prev_hs) begin
        if (fall1 == 0) fall1 = i;
        else if (fall2 == 0) fall2 = i;
      end
      prev_hs = O_hs;
    end
    check("m1_hs_low", run, 136);
    check("m1_hs_fall1", fall1, 1);
    check("m1_hs_period", fall2 - fall1, 1344);
    check("m1_vs_low", vs_cnt, 6 * 1344);
    check("m1_no_de_in_vblank", de_cnt, 0);

    // Mode 0: line period, VS width, SOF latency, first active line.
`ifdef TEST_PATTERN_EN
    I_pat_sel = 2'd0;
`endif
    apply_reset(2'd0, 1'b0, 1'b0);
    n = 0; vs_cnt = 0; rise1 = 0; rise2 = 0;
    prev_hs = O_hs;
    do begin
      step();
      n++;
      if (O_vs) vs_cnt++;
      if (O_hs && !prev_hs) begin
        if (rise1 == 0) rise1 = n;
        else if (rise2 == 0) rise2 = n;
      end
      prev_hs = O_hs;
    end while (!O_sof && n < 45000);
    check("m0_sof_latency", n, 260 + 25 * 1650 + 1);
    check("m0_hs_rise1", rise1, 1);
    check("m0_hs_period", rise2 - rise1, 1650);
    check("m0_vs_high", vs_cnt, 5 * 1650);
    check("m0_sof_de", O_de, 1'b1);
    check("m0_sof_xy", {O_x, O_y}, 0);
    run = 1; last_x = 0; n = 0;
    rgb159 = 24'h123456; rgb160 = 24'h123456; rgb1279 = 24'h123456;
    do begin
      step();
      n++;
      if (O_de) begin
        run++;
        last_x = int'(O_x);
`ifdef TEST_PATTERN_EN
        if (O_x == 12'd159)  rgb159  = O_data_rgb;
        if (O_x == 12'd160)  rgb160  = O_data_rgb;
        if (O_x == 12'd1279) rgb1279 = O_data_rgb;
`endif
      end
    end while (O_de && n < 1400);
    check("m0_de_per_line", run, 1280);
    check("m0_last_x", last_x, 1279);
`ifdef TEST_PATTERN_EN
    check("m0_bar_x159", rgb159, 24'hFFFFFF);
    check("m0_bar_x160", rgb160, 24'hFFFF00);
    check("m0_bar_x1279", rgb1279, 24'h000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
